// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: round-robin Avalon-MM arbiter sharing one bus between fetch (port 0) and load/store (port 1)
module mips_cpu_bus_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] p0_address,
    input  logic        p0_read,
    output logic        p0_waitrequest,
    output logic [31:0] p0_readdata,
    input  logic [31:0] p1_address,
    input  logic        p1_read,
    input  logic        p1_write,
    input  logic [31:0] p1_writedata,
    input  logic [3:0]  p1_byteenable,
    output logic        p1_waitrequest,
    output logic [31:0] p1_readdata,
    output logic [31:0] mem_address,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] memwritedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] memreaddata,
    output logic        timeout_err,
    output logic        protocol_err
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);
    state_t state, state_next;
    logic last;
    logic [15:0] stall_cnt;
    logic g0, g1, granted, req1;
    assign g0 = state == GRANT0;
    assign g1 = state == GRANT1;
    assign granted = g0 | g1;
    assign req1 = p1_read | p1_write;
    always_comb begin
        state_next = state;
        if (state == IDLE)
            state_next = (p0_read && (!req1 || last)) ? GRANT0 : req1 ? GRANT1 : IDLE;
        else if (!waitrequest)
            state_next = IDLE;
    end
    assign mem_address    = g0 ? p0_address : g1 ? p1_address : '0;
    assign memread        = g0 ? p0_read : g1 & p1_read & ~p1_write;
    assign memwrite       = g1 & p1_write;
    assign memwritedata   = g1 ? p1_writedata : '0;
    assign byteenable     = g0 ? 4'hF : g1 ? p1_byteenable : 4'h0;
    assign p0_waitrequest = !(g0 && !waitrequest);
    assign p1_waitrequest = !(g1 && !waitrequest);
    assign p0_readdata    = memreaddata;
    assign p1_readdata    = memreaddata;
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last         <= 1'b1;
            stall_cnt    <= '0;
            timeout_err  <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_next;
            if (granted && !waitrequest)
                last <= g1;
            stall_cnt <= !granted ? '0 : (waitrequest && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
            if (granted && waitrequest && stall_cnt == STALL_LIMIT)
                timeout_err <= 1'b1;
            if (g1 && p1_read && p1_write)
                protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// tb_mips_cpu_bus_arbiter: directed scenarios plus randomized saturating traffic against a transaction-level model
module tb_mips_cpu_bus_arbiter;
    typedef logic [69:0] bus_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        wr;
    } tx_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] p0_address = '0;
    logic        p0_read = 1'b0;
    logic        p0_waitrequest;
    logic [31:0] p0_readdata;
    logic [31:0] p1_address = '0;
    logic        p1_read = 1'b0;
    logic        p1_write = 1'b0;
    logic [31:0] p1_writedata = '0;
    logic [3:0]  p1_byteenable = '0;
    logic        p1_waitrequest;
    logic [31:0] p1_readdata;
    logic [31:0] mem_address;
    logic        memread;
    logic        memwrite;
    logic [31:0] memwritedata;
    logic [3:0]  byteenable;
    logic        waitrequest = 1'b0;
    logic [31:0] memreaddata = '0;
    logic        timeout_err;
    logic        protocol_err;

    int checks = 0;
    int failures = 0;
    tx_t cur [2];

    mips_cpu_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .p0_address(p0_address), .p0_read(p0_read),
        .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata),
        .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write),
        .p1_writedata(p1_writedata), .p1_byteenable(p1_byteenable),
        .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata),
        .mem_address(mem_address), .memread(memread), .memwrite(memwrite),
        .memwritedata(memwritedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .memreaddata(memreaddata),
        .timeout_err(timeout_err), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    function automatic bus_t bus_vec();
        return {mem_address, memread, memwrite, memwritedata, byteenable};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        p0_address = '0; p0_read = 0; p1_address = '0; p1_read = 0; p1_write = 0;
        p1_writedata = '0; p1_byteenable = '0; waitrequest = 0; memreaddata = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        p0_read = 1; p1_write = 1; p0_address = 32'h1234; p1_address = 32'h5678;
        memreaddata = 32'h13572468;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_vec() !== '0) begin failures++; $display("FAIL reset_bus got=%h want=0", bus_vec()); end
        checks++;
        if ({p0_waitrequest, p1_waitrequest} !== 2'b11) begin failures++; $display("FAIL reset_wait got=%b want=11", {p0_waitrequest, p1_waitrequest}); end
        checks++;
        if ({timeout_err, protocol_err} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b want=00", {timeout_err, protocol_err}); end
        checks++;
        if (p0_readdata !== 32'h13572468 || p1_readdata !== 32'h13572468) begin failures++; $display("FAIL reset_rdata got=%h/%h want=13572468", p0_readdata, p1_readdata); end
        do_reset();
    endtask

    task automatic test_single_fetch();
        do_reset();
        p0_read = 1; p0_address = 32'hBFC00000; waitrequest = 0; memreaddata = 32'h24020005;
        @(negedge clk);
        checks++;
        if (memread !== 1'b0 || p0_waitrequest !== 1'b1) begin failures++; $display("FAIL fetch_c1 got rd=%b w=%b want rd=0 w=1", memread, p0_waitrequest); end
        step();
        @(negedge clk);
        checks++;
        if (bus_vec() !== {32'hBFC00000, 1'b1, 1'b0, 32'h0, 4'hF}) begin failures++; $display("FAIL fetch_c2_bus got=%h want=%h", bus_vec(), {32'hBFC00000, 1'b1, 1'b0, 32'h0, 4'hF}); end
        checks++;
        if ({p0_waitrequest, p1_waitrequest} !== 2'b01 || p0_readdata !== 32'h24020005) begin failures++; $display("FAIL fetch_c2_resp got w=%b d=%h want w=01 d=24020005", {p0_waitrequest, p1_waitrequest}, p0_readdata); end
        step();
        p0_read = 0;
        @(negedge clk);
        checks++;
        if (bus_vec() !== '0 || p0_waitrequest !== 1'b1) begin failures++; $display("FAIL fetch_c3 got bus=%h w=%b want bus=0 w=1", bus_vec(), p0_waitrequest); end
    endtask

    task automatic test_tie();
        int exp_port = 0;
        do_reset();
        p0_read = 1; p0_address = 32'h100; p1_read = 1; p1_address = 32'h200; p1_byteenable = 4'hF; waitrequest = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if (c % 2 == 1) begin
                if ({p0_waitrequest, p1_waitrequest} !== 2'b11) begin failures++; $display("FAIL tie_bubble c=%0d got=%b want=11", c, {p0_waitrequest, p1_waitrequest}); end
            end else begin
                if ({p0_waitrequest, p1_waitrequest} !== (exp_port == 0 ? 2'b01 : 2'b10)) begin
                    failures++; $display("FAIL tie_grant c=%0d got=%b want_port=%0d", c, {p0_waitrequest, p1_waitrequest}, exp_port);
                end
                exp_port ^= 1;
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_store_wait();
        bus_t exp_bus = {32'h1000, 1'b0, 1'b1, 32'hDEADBEEF, 4'b0011};
        do_reset();
        p1_write = 1; p1_address = 32'h1000; p1_writedata = 32'hDEADBEEF; p1_byteenable = 4'b0011; waitrequest = 1;
        @(negedge clk);
        checks++;
        if (bus_vec() !== '0) begin failures++; $display("FAIL store_idle got=%h want=0", bus_vec()); end
        step();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) waitrequest = 0;
            @(negedge clk);
            checks++;
            if (bus_vec() !== exp_bus || p1_waitrequest !== (k < 4)) begin
                failures++; $display("FAIL store_k%0d got bus=%h w=%b want bus=%h w=%b", k, bus_vec(), p1_waitrequest, exp_bus, k < 4);
            end
            step();
        end
        p1_write = 0;
        @(negedge clk);
        checks++;
        if (memwrite !== 1'b0 || bus_vec() !== '0) begin failures++; $display("FAIL store_after got=%h want=0", bus_vec()); end
    endtask

    task automatic test_timeout();
        do_reset();
        p0_read = 1; p0_address = 32'h40; waitrequest = 1;
        @(negedge clk);
        step();
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (timeout_err !== (k > 4) || memread !== 1'b1 || p0_waitrequest !== 1'b1) begin
                failures++; $display("FAIL timeout_k%0d got err=%b rd=%b w=%b want err=%b rd=1 w=1", k, timeout_err, memread, p0_waitrequest, k > 4);
            end
            step();
        end
        waitrequest = 0;
        @(negedge clk);
        checks++;
        if (p0_waitrequest !== 1'b0 || timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_done got w=%b err=%b want w=0 err=1", p0_waitrequest, timeout_err); end
        step();
        p0_read = 0;
        @(negedge clk);
        checks++;
        if (memread !== 1'b0 || p0_waitrequest !== 1'b1 || timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_idle got rd=%b w=%b err=%b want 0 1 1", memread, p0_waitrequest, timeout_err); end
    endtask

    task automatic test_protocol();
        do_reset();
        p1_read = 1; p1_write = 1; p1_address = 32'h80; p1_writedata = 32'hA5A5A5A5; p1_byteenable = 4'hF; waitrequest = 0;
        @(negedge clk);
        checks++;
        if (protocol_err !== 1'b0) begin failures++; $display("FAIL proto_idle got=%b want=0", protocol_err); end
        step();
        @(negedge clk);
        checks++;
        if ({memread, memwrite, p1_waitrequest, protocol_err} !== 4'b0100) begin failures++; $display("FAIL proto_grant got rd/wr/w/err=%b want=0100", {memread, memwrite, p1_waitrequest, protocol_err}); end
        step();
        p1_read = 0; p1_write = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (protocol_err !== 1'b1) begin failures++; $display("FAIL proto_sticky k=%0d got=%b want=1", k, protocol_err); end
            step();
        end
        reset = 1;
        step();
        @(negedge clk);
        checks++;
        if (protocol_err !== 1'b0) begin failures++; $display("FAIL proto_reset got=%b want=0", protocol_err); end
        reset = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        p1_read = 1; p1_address = 32'h3000; p1_byteenable = 4'hF; waitrequest = 1;
        @(negedge clk);
        step();
        repeat (5) begin
            @(negedge clk);
            step();
        end
        reset = 1;
        @(negedge clk);
        checks++;
        if (memread !== 1'b1 || timeout_err !== 1'b1) begin failures++; $display("FAIL rmid_pre got rd=%b err=%b want 1 1", memread, timeout_err); end
        step();
        @(negedge clk);
        checks++;
        if (bus_vec() !== '0 || {p0_waitrequest, p1_waitrequest} !== 2'b11 || {timeout_err, protocol_err} !== 2'b00) begin
            failures++; $display("FAIL rmid_post got bus=%h w=%b err=%b want 0 11 00", bus_vec(), {p0_waitrequest, p1_waitrequest}, {timeout_err, protocol_err});
        end
        reset = 0; p0_read = 1; p0_address = 32'h4000; waitrequest = 0;
        step();
        @(negedge clk);
        checks++;
        if ({p0_waitrequest, p1_waitrequest} !== 2'b01 || mem_address !== 32'h4000) begin
            failures++; $display("FAIL rmid_tie got w=%b addr=%h want w=01 addr=00004000", {p0_waitrequest, p1_waitrequest}, mem_address);
        end
        clear_inputs();
    endtask

    task automatic new_tx(input int p);
        cur[p].addr = $urandom;
        cur[p].data = $urandom;
        cur[p].be   = 4'($urandom_range(1, 15));
        cur[p].wr   = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (p == 0) begin
            p0_address = cur[0].addr; p0_read = 1;
        end else begin
            p1_address = cur[1].addr; p1_read = !cur[1].wr; p1_write = cur[1].wr;
            p1_writedata = cur[1].data; p1_byteenable = cur[1].be;
        end
    endtask

    // Both requesters stay saturated: expect strict alternation, port 0 first, one idle cycle between grants.
    task automatic test_random();
        int exp_port = 0, ntx = 0, wl = 0, done_port = -1;
        bit bubble = 1, busy = 0;
        bus_t exp_bus;
        logic [31:0] rd_val;
        do_reset();
        new_tx(0);
        new_tx(1);
        for (int cyc = 0; cyc < 800 && ntx < 40; cyc++) begin
            #1;
            if (!busy && (memread || memwrite)) begin
                busy = 1;
                wl = $urandom_range(0, 3);
            end
            waitrequest = busy && wl > 0;
            rd_val = $urandom;
            memreaddata = rd_val;
            @(negedge clk);
            checks++;
            if (bubble) begin
                if (bus_vec() !== '0 || {p0_waitrequest, p1_waitrequest} !== 2'b11) begin
                    failures++; $display("FAIL rand_bubble tx=%0d got bus=%h w=%b want bus=0 w=11", ntx, bus_vec(), {p0_waitrequest, p1_waitrequest});
                end
                bubble = 0;
            end else begin
                exp_bus = (exp_port == 0) ? {cur[0].addr, 1'b1, 1'b0, 32'h0, 4'hF}
                                          : {cur[1].addr, !cur[1].wr, cur[1].wr, cur[1].data, cur[1].be};
                if (bus_vec() !== exp_bus) begin
                    failures++; $display("FAIL rand_bus tx=%0d port=%0d got=%h want=%h", ntx, exp_port, bus_vec(), exp_bus);
                end
                checks++;
                if ({p0_waitrequest, p1_waitrequest} !== (wl > 0 ? 2'b11 : (exp_port == 0 ? 2'b01 : 2'b10))) begin
                    failures++; $display("FAIL rand_wait tx=%0d port=%0d wl=%0d got=%b", ntx, exp_port, wl, {p0_waitrequest, p1_waitrequest});
                end
                if (wl == 0) begin
                    if (!cur[exp_port].wr) begin
                        checks++;
                        if ((exp_port == 0 ? p0_readdata : p1_readdata) !== rd_val) begin
                            failures++; $display("FAIL rand_rdata tx=%0d port=%0d got=%h want=%h", ntx, exp_port, exp_port == 0 ? p0_readdata : p1_readdata, rd_val);
                        end
                    end
                    done_port = exp_port;
                    exp_port ^= 1;
                    bubble = 1;
                    busy = 0;
                    ntx++;
                end else begin
                    wl--;
                end
            end
            step();
            if (done_port >= 0) begin
                new_tx(done_port);
                done_port = -1;
            end
        end
        checks++;
        if (ntx < 40) begin failures++; $display("FAIL rand_budget got=%0d transactions want=40", ntx); end
        checks++;
        if ({timeout_err, protocol_err} !== 2'b00) begin failures++; $display("FAIL rand_err got=%b want=00", {timeout_err, protocol_err}); end
        clear_inputs();
    endtask

    initial begin
        #1;
        test_reset();
        test_single_fetch();
        test_tie();
        test_store_wait();
        test_timeout();
        test_protocol();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
